// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory signal bundle for load_store_unit.
// master: the load/store unit itself (accepts CPU requests, initiates memory accesses).
// slave:  the surrounding environment (CPU pipeline plus the Memory block).
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_wr_data;
    logic [1:0]        mem_wr_mask;
    logic [2:0]        mem_rd_mask;
    logic [31:0]       mem_rd_data;
    logic              mem_err_misaligned;
    logic              mem_err_rdmask;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata,
        input  mem_rd_data, mem_err_misaligned, mem_err_rdmask,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_wr_data, mem_wr_mask, mem_rd_mask
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata,
        output mem_rd_data, mem_err_misaligned, mem_err_rdmask,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_wr_data, mem_wr_mask, mem_rd_mask
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store initiator for the byte-laned data memory.
// Checks opcode and alignment, issues one memory access, waits out the registered
// read and returns a single-cycle response.
// Optional: define LSU_MISALIGNED_SPLIT_EN to split misaligned half/word accesses
// into consecutive byte accesses instead of rejecting them.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input logic               i_clk,
    input logic               i_reset,
    load_store_unit_if.master bus
);
    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LHU = 4'd2;
    localparam logic [3:0] OP_LB  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [2:0] RD_NONE = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    state_t state, state_nx;

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        err_q;

    logic req_load, req_store, req_half, req_word, req_misal;
    logic op_load, mem_err;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic        split_q;
    logic [1:0]  cnt_q;
    logic [31:0] acc_q;
    logic        split_last;
`endif

    // Decode the incoming request and the latched opcode
    always_comb begin
        req_load  = bus.req_op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
        req_store = bus.req_op inside {OP_SB, OP_SH, OP_SW};
        req_half  = bus.req_op inside {OP_LH, OP_LHU, OP_SH};
        req_word  = bus.req_op inside {OP_LW, OP_SW};
        req_misal = (req_half && bus.req_addr[0]) ||
                    (req_word && (bus.req_addr[1:0] != 2'b00));
        op_load   = op_q inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
        mem_err   = bus.mem_err_misaligned || bus.mem_err_rdmask;
`ifdef LSU_MISALIGNED_SPLIT_EN
        split_last = (cnt_q == ((op_q inside {OP_LW, OP_SW}) ? 2'd3 : 2'd1));
`endif
    end

    // State register and request/error latches
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state == S_IDLE && bus.req_valid) begin
                op_q    <= bus.req_op;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                if (!(req_load || req_store))
                    err_q <= 2'd2;
`ifdef LSU_MISALIGNED_SPLIT_EN
                else
                    err_q <= 2'd0;
                split_q <= (req_load || req_store) && req_misal;
                cnt_q   <= '0;
                acc_q   <= '0;
`else
                else if (req_misal)
                    err_q <= 2'd1;
                else
                    err_q <= 2'd0;
`endif
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            // Each split WAIT deposits one byte; a memory error is sticky until RESP
            if (state == S_WAIT && split_q) begin
                acc_q[{cnt_q, 3'b000} +: 8] <= bus.mem_rd_data[7:0];
                if (mem_err)
                    err_q <= 2'd3;
                cnt_q <= cnt_q + 2'd1;
            end
`endif
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_nx        = state;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.resp_err    = '0;
        bus.mem_address = '0;
        bus.mem_wr_data = '0;
        bus.mem_wr_mask = 2'd0;
        bus.mem_rd_mask = RD_NONE;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (!(req_load || req_store))
                        state_nx = S_RESP;
                    else if (req_misal)
`ifdef LSU_MISALIGNED_SPLIT_EN
                        state_nx = S_ISSUE;
`else
                        state_nx = S_RESP;
`endif
                    else
                        state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx        = S_WAIT;
                bus.mem_address = addr_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (split_q) begin
                    bus.mem_address = addr_q + ADDR_W'(cnt_q);
                    if (op_load) begin
                        bus.mem_rd_mask = 3'd2;
                    end else begin
                        bus.mem_wr_mask = 2'd1;
                        bus.mem_wr_data = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
                    end
                end else
`endif
                if (op_load) begin
                    case (op_q)
                        OP_LHU:  bus.mem_rd_mask = 3'd1;
                        OP_LBU:  bus.mem_rd_mask = 3'd2;
                        OP_LH:   bus.mem_rd_mask = 3'd3;
                        OP_LB:   bus.mem_rd_mask = 3'd4;
                        default: bus.mem_rd_mask = 3'd0;
                    endcase
                end else begin
                    bus.mem_wr_data = wdata_q;
                    case (op_q)
                        OP_SB:   bus.mem_wr_mask = 2'd1;
                        OP_SH:   bus.mem_wr_mask = 2'd2;
                        default: bus.mem_wr_mask = 2'd3;
                    endcase
                end
            end
            S_WAIT: begin
                state_nx = S_IDLE;
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (split_q) begin
                    state_nx = split_last ? S_RESP : S_ISSUE;
                end else begin
`endif
                    bus.resp_valid = 1'b1;
                    bus.resp_err   = mem_err ? 2'd3 : 2'd0;
                    bus.resp_rdata = (op_load && !mem_err) ? bus.mem_rd_data : '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                end
`endif
            end
            S_RESP: begin
                state_nx       = S_IDLE;
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (split_q && op_load && err_q == 2'd0) begin
                    case (op_q)
                        OP_LH:   bus.resp_rdata = {{16{acc_q[15]}}, acc_q[15:0]};
                        OP_LHU:  bus.resp_rdata = {16'd0, acc_q[15:0]};
                        default: bus.resp_rdata = acc_q;
                    endcase
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase
        // Reset overrides the state decode so an aborted store never reaches memory
        if (i_reset) begin
            bus.mem_wr_mask = 2'd0;
            bus.resp_valid  = 1'b0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench for load_store_unit.
// A byte-laned memory model answers the unit; an op-level reference model predicts
// response timing, data, error code and the exact memory-bus activity per request.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();
    load_store_unit #(.ADDR_W(32)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory model: byte array, writes on the edge, registered read and error flags
    logic [7:0] dmem [0:255] = '{default: 8'h00};
    logic [7:0] a8;
    logic       inj_err, inj_sel;
    assign a8 = bus.mem_address[7:0];

    always @(posedge clk) begin
        case (bus.mem_wr_mask)
            2'd1: dmem[a8] <= bus.mem_wr_data[7:0];
            2'd2: begin
                dmem[a8]       <= bus.mem_wr_data[7:0];
                dmem[a8+8'd1]  <= bus.mem_wr_data[15:8];
            end
            2'd3: begin
                dmem[a8]       <= bus.mem_wr_data[7:0];
                dmem[a8+8'd1]  <= bus.mem_wr_data[15:8];
                dmem[a8+8'd2]  <= bus.mem_wr_data[23:16];
                dmem[a8+8'd3]  <= bus.mem_wr_data[31:24];
            end
            default: ;
        endcase
        case (bus.mem_rd_mask)
            3'd0: bus.mem_rd_data <= {dmem[a8+8'd3], dmem[a8+8'd2], dmem[a8+8'd1], dmem[a8]};
            3'd1: bus.mem_rd_data <= {16'd0, dmem[a8+8'd1], dmem[a8]};
            3'd2: bus.mem_rd_data <= {24'd0, dmem[a8]};
            3'd3: bus.mem_rd_data <= {{16{dmem[a8+8'd1][7]}}, dmem[a8+8'd1], dmem[a8]};
            3'd4: bus.mem_rd_data <= {{24{dmem[a8][7]}}, dmem[a8]};
            default: bus.mem_rd_data <= 32'd0;
        endcase
        bus.mem_err_misaligned <= inj_err && !inj_sel && (bus.mem_rd_mask != 3'd5);
        bus.mem_err_rdmask     <= inj_err &&  inj_sel && (bus.mem_rd_mask != 3'd5);
    end

    // Reference memory contents as seen by the program (bytes, address modulo 256 here)
    logic [7:0] rmem [0:255] = '{default: 8'h00};

    // One request: predict, drive, observe every cycle until idle again, compare
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic inj_in, input string tag);
        bit          is_load, is_store, misal, inj;
        int unsigned nbytes, exp_lat, resp_k, ready_k, n_resp;
        logic [1:0]  exp_err, got_err;
        logic [31:0] exp_rdata, got_rdata, v, a;
        logic [68:0] exp_bus[$];
        logic [68:0] got_bus[$];

        is_load  = (op <= 4'd4);
        is_store = op inside {4'd8, 4'd9, 4'd10};
        nbytes   = (op == 4'd0 || op == 4'd10) ? 4 :
                   (op == 4'd1 || op == 4'd2 || op == 4'd9) ? 2 : 1;
        misal    = (addr % nbytes) != 0;
        inj      = inj_in && is_load && !(misal && !SPLIT);
        exp_rdata = 32'd0;
        exp_err   = 2'd0;
        if (!(is_load || is_store)) begin
            exp_lat = 1; exp_err = 2'd2;
        end else if (misal && !SPLIT) begin
            exp_lat = 1; exp_err = 2'd1;
        end else begin
            exp_lat = misal ? 2 * nbytes + 1 : 2;
            exp_err = inj ? 2'd3 : 2'd0;
            v = 32'd0;
            for (int unsigned j = 0; j < nbytes; j++) begin
                a = addr + j;
                v[8*j +: 8] = rmem[a[7:0]];
            end
            if (op == 4'd1)      v = {{16{v[15]}}, v[15:0]};
            else if (op == 4'd3) v = {{24{v[7]}}, v[7:0]};
            if (is_load && !inj) exp_rdata = v;
            for (int unsigned j = 0; j < (misal ? nbytes : 1); j++) begin
                a = addr + j;
                if (misal && is_load)
                    exp_bus.push_back({a, 2'd0, 3'd2, 32'd0});
                else if (misal)
                    exp_bus.push_back({a, 2'd1, 3'd5, 24'd0, wdata[8*j +: 8]});
                else if (is_load)
                    exp_bus.push_back({a, 2'd0,
                        (op == 4'd0) ? 3'd0 : (op == 4'd2) ? 3'd1 : (op == 4'd4) ? 3'd2 :
                        (op == 4'd1) ? 3'd3 : 3'd4, 32'd0});
                else
                    exp_bus.push_back({a, (op == 4'd8) ? 2'd1 : (op == 4'd9) ? 2'd2 : 2'd3,
                                       3'd5, wdata});
            end
            if (is_store)
                for (int unsigned j = 0; j < nbytes; j++) begin
                    a = addr + j;
                    rmem[a[7:0]] = wdata[8*j +: 8];
                end
        end

        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        inj_err       = inj;
        inj_sel       = 1'($urandom);
        check({tag, " ready"}, {127'd0, bus.req_ready}, 128'd1);
        @(posedge clk);
        resp_k = 0; ready_k = 0; n_resp = 0; got_rdata = '0; got_err = '0;
        for (int unsigned k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Junk while busy: must be ignored
                bus.req_valid = 1'($urandom);
                bus.req_op    = 4'($urandom);
                bus.req_addr  = $urandom;
                bus.req_wdata = $urandom;
            end
            if (bus.mem_wr_mask != 2'd0 || bus.mem_rd_mask != 3'd5)
                got_bus.push_back({bus.mem_address, bus.mem_wr_mask, bus.mem_rd_mask, bus.mem_wr_data});
            if (bus.resp_valid) begin
                n_resp++;
                if (resp_k == 0) begin
                    resp_k = k; got_rdata = bus.resp_rdata; got_err = bus.resp_err;
                end
            end
            if (bus.req_ready) begin
                ready_k = k;
                break;
            end
        end
        bus.req_valid = 1'b0;
        inj_err       = 1'b0;
        check({tag, " resp latency"}, 128'(resp_k), 128'(exp_lat));
        check({tag, " ready latency"}, 128'(ready_k), 128'(exp_lat + 1));
        check({tag, " pulses"}, 128'(n_resp), 128'd1);
        check({tag, " rdata"}, {96'd0, got_rdata}, {96'd0, exp_rdata});
        check({tag, " err"}, {126'd0, got_err}, {126'd0, exp_err});
        check({tag, " bus count"}, 128'(got_bus.size()), 128'(exp_bus.size()));
        for (int unsigned i = 0; i < exp_bus.size() && i < got_bus.size(); i++)
            check({tag, " bus access"}, {59'd0, got_bus[i]}, {59'd0, exp_bus[i]});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ready"},   {127'd0, bus.req_ready},   128'd1);
        check({tag, " rvalid"},  {127'd0, bus.resp_valid},  128'd0);
        check({tag, " rdata"},   {96'd0, bus.resp_rdata},   128'd0);
        check({tag, " err"},     {126'd0, bus.resp_err},    128'd0);
        check({tag, " wrmask"},  {126'd0, bus.mem_wr_mask}, 128'd0);
        check({tag, " rdmask"},  {125'd0, bus.mem_rd_mask}, 128'd5);
        check({tag, " address"}, {96'd0, bus.mem_address},  128'd0);
        check({tag, " wrdata"},  {96'd0, bus.mem_wr_data},  128'd0);
    endtask

    logic [3:0] legal_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10};

    initial begin
        logic [3:0]  op;
        logic [31:0] addr;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
        inj_err = 1'b0; inj_sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        do_req(4'd10, 32'h10, 32'hDEADBEEF, 1'b0, "SW 0x10");
        do_req(4'd0,  32'h10, 32'h0,        1'b0, "LW 0x10");
        do_req(4'd8,  32'h21, 32'h80,       1'b0, "SB 0x21");
        do_req(4'd3,  32'h21, 32'h0,        1'b0, "LB 0x21");
        do_req(4'd4,  32'h21, 32'h0,        1'b0, "LBU 0x21");
        do_req(4'd9,  32'h13, 32'h1234,     1'b0, "SH 0x13");
        do_req(4'd0,  32'h10, 32'h0,        1'b0, "LW 0x10 again");
        do_req(4'd5,  32'h00, 32'h0,        1'b0, "op5");
        do_req(4'd0,  32'h10, 32'h0,        1'b1, "LW memerr");

        // Reset during the ISSUE cycle of a store
        bus.req_valid = 1'b1; bus.req_op = 4'd10; bus.req_addr = 32'h20; bus.req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstmid issue wrmask", {126'd0, bus.mem_wr_mask}, 128'd3);
        rst = 1'b1;
        #1;
        check("rstmid forced wrmask", {126'd0, bus.mem_wr_mask}, 128'd0);
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rstmid after");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rstmid no resp", {127'd0, bus.resp_valid}, 128'd0);
        end
        do_req(4'd0, 32'h20, 32'h0, 1'b0, "LW 0x20 after abort");

        do_req(4'd10, 32'h22, 32'hA1B2C3D4, 1'b0, "SW 0x22");
        do_req(4'd0,  32'h22, 32'h0,        1'b0, "LW 0x22");
        do_req(4'd9,  32'h23, 32'h8001,     1'b0, "SH 0x23");
        do_req(4'd1,  32'h23, 32'h0,        1'b0, "LH 0x23");
        do_req(4'd10, 32'hFFFFFFFE, 32'h01020304, 1'b0, "SW wrap");
        do_req(4'd0,  32'hFFFFFFFE, 32'h0,  1'b0, "LW wrap");

        for (int unsigned i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0)
                op = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(5, 7)) : 4'($urandom_range(11, 15));
            else
                op = legal_ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 6) == 0) addr = 32'hFFFFFFF0 + $urandom_range(0, 15);
            else                           addr = $urandom_range(0, 127);
            if ($urandom_range(0, 1) != 0) addr[1:0] = 2'b00;
            do_req(op, addr, $urandom, ($urandom_range(0, 9) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
